shift_sequencer: RTL and testbench



---
 rtl/shift_sequencer.sv | 113 +++++++++++
 tb/tb_shift_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle driver for an 8-bit, 0-3 position shift unit: splits any count
// up to 2^AMT_W-1 into passes of at most three and accumulates the result.
module shift_sequencer #(
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_a,
   input  logic             in_left,
   input  logic             in_rotate,
   input  logic [AMT_W-1:0] in_amt,
   output logic [7:0]       sh_a,
   output logic             sh_left,
   output logic             sh_rotate,
   output logic [1:0]       sh_amt,
   input  logic [7:0]       sh_c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_c,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [7:0]       acc;
   logic [AMT_W-1:0] rem;
   logic             left_q;
   logic             rot_q;

   logic [1:0]       step;
   logic [AMT_W-1:0] rem_next;

   // NOTE: every variable assigned in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      step = 2'd3;
      if (rem < AMT_W'(3))
         step = rem[1:0];
      rem_next = rem - AMT_W'(step);
   end

   assign sh_a      = acc;
   assign sh_left   = left_q;
   assign sh_rotate = rot_q;
   assign sh_amt    = (state == RUN) ? step : 2'd0;
   assign out_c     = acc;

   // Handshake flags are registered alongside the state so they always
   // reflect the state entered at the same edge.
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= 8'h00;
         rem       <= '0;
         left_q    <= 1'b0;
         rot_q     <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  acc      <= in_a;
                  left_q   <= in_left;
                  rot_q    <= in_rotate;
                  rem      <= in_amt;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (in_amt == '0) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               acc <= sh_c;
               rem <= rem_next;
               if (rem_next == '0) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: models the 0-3 position shift unit on sh_*/sh_c
// and checks results, pass counts and handshakes against a scoreboard.
module tb_shift_sequencer;

   localparam int AMT_W = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_a;
   logic             in_left;
   logic             in_rotate;
   logic [AMT_W-1:0] in_amt;
   logic [7:0]       sh_a;
   logic             sh_left;
   logic             sh_rotate;
   logic [1:0]       sh_amt;
   logic [7:0]       sh_c;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_c;
   logic             busy;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string      name;
      logic [7:0] a;
      logic       left;
      logic       rot;
      int         amt;
      logic [7:0] exp_c;
      int         hold;
   } vec_t;

   typedef struct {
      logic [7:0] c;
      int         lat;
   } exp_t;

   exp_t sb[$];

   shift_sequencer #(.AMT_W(AMT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_left   (in_left),
      .in_rotate (in_rotate),
      .in_amt    (in_amt),
      .sh_a      (sh_a),
      .sh_left   (sh_left),
      .sh_rotate (sh_rotate),
      .sh_amt    (sh_amt),
      .sh_c      (sh_c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_c     (out_c),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Combinational model of the downstream shift unit.
   function automatic logic [7:0] shift_unit(input logic [7:0] a, input logic left,
                                             input logic rot, input logic [1:0] amt);
      logic [7:0] r;
      r = a;
      for (int i = 0; i < int'(amt); i++) begin
         if (left) r = rot ? {r[6:0], r[7]} : {r[6:0], 1'b0};
         else      r = rot ? {r[0], r[7:1]} : {r[7], r[7:1]};
      end
      return r;
   endfunction

   always_comb sh_c = shift_unit(sh_a, sh_left, sh_rotate, sh_amt);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_req(input vec_t v);
      exp_t e;
      int   lat;
      int   rem;
      int   step;
      check({v.name, " in_ready idle"}, in_ready, 1);
      in_valid  = 1'b1;
      in_a      = v.a;
      in_left   = v.left;
      in_rotate = v.rot;
      in_amt    = v.amt[AMT_W-1:0];
      tick();
      in_valid = 1'b0;
      in_a     = 8'h00;
      sb.push_back('{c: v.exp_c, lat: (v.amt + 2) / 3});
      lat = 0;
      rem = v.amt;
      while (!out_valid && lat < 20) begin
         step = (rem > 3) ? 3 : rem;
         check({v.name, " sh_amt pass"}, sh_amt, step);
         check({v.name, " busy run"}, busy, 1);
         check({v.name, " in_ready run"}, in_ready, 0);
         rem -= step;
         tick();
         lat++;
      end
      e = sb.pop_front();
      check({v.name, " latency"}, lat, e.lat);
      check({v.name, " out_valid"}, out_valid, 1);
      check({v.name, " out_c"}, out_c, e.c);
      check({v.name, " sh_amt done"}, sh_amt, 0);
      check({v.name, " busy done"}, busy, 1);
      for (int i = 0; i < v.hold; i++) begin
         in_valid = (i % 2 == 0);
         in_a     = 8'h11;
         tick();
         check({v.name, " hold out_c"}, out_c, e.c);
         check({v.name, " hold in_ready"}, in_ready, 0);
         check({v.name, " hold out_valid"}, out_valid, 1);
      end
      in_valid  = (v.hold > 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      in_a      = 8'h00;
      check({v.name, " out_valid drop"}, out_valid, 0);
      check({v.name, " in_ready back"}, in_ready, 1);
      check({v.name, " busy idle"}, busy, 0);
      tick();
      check({v.name, " out_c held idle"}, out_c, e.c);
      check({v.name, " no stray capture"}, busy, 0);
   endtask

   vec_t vecs[$];
   vec_t v;

   initial begin
      vecs.push_back('{"asr5",  8'h96, 1'b0, 1'b0, 5, 8'hFC, 0});
      vecs.push_back('{"lsl7",  8'hA5, 1'b1, 1'b0, 7, 8'h80, 0});
      vecs.push_back('{"rol7",  8'h96, 1'b1, 1'b1, 7, 8'h4B, 0});
      vecs.push_back('{"ror4",  8'h96, 1'b0, 1'b1, 4, 8'h69, 0});
      vecs.push_back('{"zero",  8'h3C, 1'b0, 1'b0, 0, 8'h3C, 0});
      vecs.push_back('{"ror6",  8'h81, 1'b0, 1'b1, 6, 8'h06, 0});
      vecs.push_back('{"lsl3",  8'h01, 1'b1, 1'b0, 3, 8'h08, 0});
      vecs.push_back('{"hold",  8'h5A, 1'b1, 1'b1, 3, 8'hD2, 5});

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = 8'h00;
      in_left   = 1'b0;
      in_rotate = 1'b0;
      in_amt    = '0;
      out_ready = 1'b0;
      tick();
      tick();
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset busy", busy, 0);
      check("reset sh_amt", sh_amt, 0);
      check("reset out_c", out_c, 8'h00);
      rst_n = 1'b1;
      tick();

      foreach (vecs[i]) run_req(vecs[i]);

      // Abort an amt=7 request with reset at its second RUN edge.
      in_valid  = 1'b1;
      in_a      = 8'hA5;
      in_left   = 1'b1;
      in_rotate = 1'b0;
      in_amt    = 3'd7;
      tick();
      in_valid = 1'b0;
      tick();
      check("abort mid-run busy", busy, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort out_valid", out_valid, 0);
      check("abort out_c", out_c, 8'h00);
      check("abort in_ready", in_ready, 1);
      check("abort busy", busy, 0);
      check("abort sh_amt", sh_amt, 0);
      tick();
      check("abort stays idle", out_valid, 0);

      v = '{"post_abort_asr1", 8'h80, 1'b0, 1'b0, 1, 8'hC0, 0};
      run_req(v);

      check("scoreboard empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
